// File: rtl/shumezuesi_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package shumezuesi_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    LLOGARIT = 1'b1
  } state_e;

  // Counter width wide enough to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shumezuesi_hap.sv
// One shift-add iteration: add the masked multiplicand to the upper half and
// shift the whole accumulator right by one, carry entering the top bit.
module shumezuesi_hap #(
  parameter int WIDTH = 8
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic               b_bit_i,
  output logic [2*WIDTH-1:0] acc_o
);

  localparam int AW = 2 * WIDTH;

  logic [WIDTH:0] sum;

  always_comb begin
    sum   = {1'b0, acc_i[AW-1:WIDTH]} + (b_bit_i ? {1'b0, a_i} : '0);
    acc_o = AW'({sum, acc_i[WIDTH-1:0]} >> 1);
  end

endmodule

// File: rtl/shumezuesi_sekuencial.sv
// Sequential radix-2 multiplier with start/done handshake and zero-operand shortcut.
// Two's-complement mode is compiled in with SHUMEZUESI_SIGNED_EN.
//
// state    | meaning
// IDLE     | waiting for start; zero operands answered here directly
// LLOGARIT | one partial-product step per clock, WIDTH steps total
module shumezuesi_sekuencial
  import shumezuesi_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prodhimi
);

  localparam int CW = cnt_width(WIDTH);
  localparam int AW = 2 * WIDTH;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [AW-1:0]     prod_q, prod_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              done_q, done_d;

  logic [AW-1:0]     acc_step;
  logic [AW-1:0]     acc_final;
  logic [WIDTH-1:0]  a_mag;
  logic [WIDTH-1:0]  b_mag;
  logic              zero_op;

  assign zero_op = (a == '0) || (b == '0);

  shumezuesi_hap #(.WIDTH(WIDTH)) u_hap (
    .acc_i   (acc_q),
    .a_i     (a_q),
    .b_bit_i (b_q[0]),
    .acc_o   (acc_step)
  );

`ifdef SHUMEZUESI_SIGNED_EN
  logic neg_q, neg_d;

  // Most-negative value negates to itself, which read unsigned is its magnitude.
  assign a_mag     = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign b_mag     = b[WIDTH-1] ? (~b + 1'b1) : b;
  assign acc_final = neg_q ? (~acc_step + 1'b1) : acc_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) neg_q <= 1'b0;
    else        neg_q <= neg_d;
  end

  always_comb begin
    neg_d = neg_q;
    if (state_q == IDLE && start && !zero_op) neg_d = a[WIDTH-1] ^ b[WIDTH-1];
  end
`else
  assign a_mag     = a;
  assign b_mag     = b;
  assign acc_final = acc_step;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (zero_op) begin
            prod_d = '0;
            done_d = 1'b1;
          end else begin
            a_d     = a_mag;
            b_d     = b_mag;
            acc_d   = '0;
            cnt_d   = CW'(WIDTH);
            state_d = LLOGARIT;
          end
        end
      end
      LLOGARIT: begin
        acc_d = acc_step;
        b_d   = b_q >> 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          prod_d  = acc_final;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == LLOGARIT);
  assign done     = done_q;
  assign prodhimi = prod_q;

endmodule

// File: doc/shumezuesi_sekuencial.md
# shumezuesi_sekuencial

Parametrised sequential radix-2 shift-add multiplier, the clocked successor of the team's combinational 8x8 multiplier. It accepts two WIDTH-bit operands through a start/done handshake and computes the 2*WIDTH-bit product one partial-product step per clock. The zero-operand shortcut from the combinational version is kept. An optional two's-complement mode is compiled in by macro. It sits in the datapath wherever a multiply is too wide or too slow to close timing combinationally.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while idle.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when prodhimi is valid.
- prodhimi  output  2*WIDTH  product; registered and held until the next accepted start.

## Operation
- States:
  - IDLE: waiting for start.
  - LLOGARIT: iterating.
- IDLE with start=1, and a and b both nonzero:
  - Latch a into a_reg and b into b_reg.
  - Clear the accumulator.
  - Load counter = WIDTH.
  - Go to LLOGARIT.
- IDLE with start=1, and a==0 or b==0:
  - prodhimi <= 0 and done <= 1.
  - Stay in IDLE. No iteration runs.
- LLOGARIT, each cycle:
  - acc <= {(b_reg[0] ? a_reg : 0) + acc[2W-1:W], acc[W-1:1]}. The sum is WIDTH+1 bits wide; its carry enters the top bit.
  - b_reg <= b_reg >> 1.
  - counter <= counter - 1.
- LLOGARIT, iteration where counter==1:
  - prodhimi <= final accumulator value.
  - done <= 1.
  - Go to IDLE.
- start is ignored while busy. Operands are not re-sampled, and a and b may change freely during LLOGARIT.
- A start asserted in the cycle where done is high is accepted, because the FSM is already in IDLE. Back-to-back operation has no bubble.
- Result is exact; no overflow is possible. The counter is $clog2(WIDTH+1) bits.
- Reset values: state=IDLE, busy=0, done=0, prodhimi=0, internal registers=0.
- Reset asserted mid-operation aborts the operation immediately. No done is produced for it.

## Timing
- Call the edge that accepts start "edge 0".
- Nonzero operands:
  - Iterations occur on edges 1..WIDTH.
  - busy is high from after edge 0 until after edge WIDTH.
  - done is high for exactly the cycle following edge WIDTH.
  - Latency is WIDTH cycles from acceptance to done.
- Zero operand:
  - done is high in the cycle after edge 0.
  - busy never rises.
  - Latency is 1 cycle.
- Maximum throughput is one product per WIDTH cycles.
- prodhimi changes only on the edge that raises done, or on reset.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- SHUMEZUESI_SIGNED_EN defined:
  - a, b and prodhimi are two's complement.
  - On acceptance, the magnitudes |a| and |b| are latched, plus neg = a[W-1]^b[W-1].
  - The final write stores neg ? -acc : acc. Negation is folded into the last iteration, so latency is unchanged.
  - -2^(W-1) is handled as magnitude 2^(W-1). (-2^(W-1))^2 fits in 2*WIDTH signed bits.
- SHUMEZUESI_SIGNED_EN undefined:
  - Operands and result are unsigned.
  - No sign logic is instantiated.

## Structure
- Package shumezuesi_pkg holds:
  - The state typedef (IDLE, LLOGARIT).
  - The count-width function clog2-based on WIDTH.
- One sub-module, shumezuesi_hap: the combinational single-iteration step, taking (acc, a_reg, b_bit) and returning the next acc.
- The top level holds the FSM, counter, operand registers, sign logic and output register.

## Test plan
All scenarios use WIDTH=8 unless stated.
- a=13, b=11, start for one cycle -> busy for 8 cycles, done on the 8th cycle after acceptance, prodhimi=143 (0x008F).
- a=255, b=255 -> prodhimi=65025 (0xFE01). Checks carry into the top bit.
- a=0, b=200 -> done one cycle after acceptance, prodhimi=0, busy never high. Repeat with a=77, b=0.
- Start a=6, b=7. Hold start high and change a and b during busy -> ignored, prodhimi=42. Assert start with a=2, b=3 in the done cycle -> accepted, next result 6 after 8 cycles.
- Start a=100, b=100, then pull rst_n low at iteration 4 -> all outputs 0 immediately, no done. After release, a=3, b=4 gives 12.
- a=0xFD, b=0x05:
  - With SHUMEZUESI_SIGNED_EN -> prodhimi=0xFFF1 (-15).
  - Without it -> prodhimi=1265 (0x04F1).
  - With the macro, a=0x80, b=0x80 -> 0x4000.
  - Also cover WIDTH=16: a=0xFFFF, b=0xFFFF -> 0xFFFE0001, unsigned, after 16 cycles.
